// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: FSM state encodings, frame bit indices and parity helper.
// Used by both the host transmitter and the keyboard receiver.
package ps2_defs;

    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_PAR_IDX   = 8;
    localparam int PS2_STOP_IDX  = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_t;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data pads, plus a
// single-cycle pulse on each falling edge of the synchronized clock.
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle PS/2 lines float high, so every stage resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk};
            data_ff  <= {data_ff[0], ps2_data};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];
    assign fall   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// start/8 data/parity/stop on device clock falls, then check the device ACK.
module ps2_tx
    import ps2_defs::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output ps2_state_t state_dbg
);

    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    PAR_CNT  = 4'(PS2_PAR_IDX);
    localparam logic [3:0]    STOP_CNT = 4'(PS2_STOP_IDX);

    logic clk_s, data_s, fall;

    ps2_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .fall     (fall)
    );

    ps2_state_t           state, state_d;
    logic [TW-1:0]        timer, timer_d;
    logic [3:0]           bit_cnt, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift, shift_d;
    logic                 par, par_d;
    logic                 data_oe_q, data_oe_d;
    logic                 done_d, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par       <= 1'b0;
            data_oe_q <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            par       <= par_d;
            data_oe_q <= data_oe_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Handshake: a byte transfers on any clk edge where tx_valid & tx_ready;
    // tx_ready is high only in IDLE, and tx_data is captured on that edge only.
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        par_d     = par;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d   = ST_INHIBIT;
                    shift_d   = tx_data;
                    par_d     = odd_parity(tx_data);
                    bit_cnt_d = '0;
                    timer_d   = '0;
                end
            end
            ST_INHIBIT: begin
                if (timer == INH_LAST) begin
                    state_d = ST_REQ;
                    timer_d = '0;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            ST_REQ: begin
                // Start bit stays on the data line until the device's first fall.
                state_d   = ST_SEND;
                timer_d   = '0;
                data_oe_d = 1'b1;
            end
            ST_SEND: begin
                if (fall) begin
                    timer_d   = '0;
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt < PAR_CNT) begin
                        data_oe_d = ~shift[bit_cnt[2:0]];
                    end else if (bit_cnt == PAR_CNT) begin
                        data_oe_d = ~par;
                    end else begin
                        data_oe_d = 1'b0;
                        if (bit_cnt == STOP_CNT) state_d = ST_ACK;
                    end
                end else if (timer == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            ST_ACK: begin
                if (fall) begin
                    timer_d = '0;
                    if (data_s) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else if (timer == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // Bus-idle wins over a same-cycle timeout so done and err never coincide.
                if (clk_s && data_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (fall) begin
                    timer_d = '0;
                end else if (timer == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_ready    = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_REQ);
    assign ps2_data_oe = (state == ST_REQ) || ((state == ST_SEND) && data_oe_q);
    assign state_dbg   = state;

endmodule
